bp_be_fe_queue_buffer: RTL



---
 rtl/bp_be_fe_queue_buffer.sv | 102 ++++++++++
 1 files changed

// File: rtl/bp_be_fe_queue_buffer.sv
// Replay buffer between FE fetch output and BE issue: entries persist until committed so the BE can roll back and replay.
// Optional same-cycle bypass into an empty read side is enabled by defining BP_BE_FE_QUEUE_BYPASS_EN.
module bp_be_fe_queue_buffer #(
    parameter int unsigned els_p   = 8,
    parameter int unsigned width_p = 128
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] fe_queue_i,
    input  logic               fe_queue_v_i,
    output logic               fe_queue_ready_o,
    output logic [width_p-1:0] fe_queue_o,
    output logic               fe_queue_v_o,
    input  logic               fe_queue_yumi_i,
    input  logic               deq_v_i,
    input  logic               roll_v_i,
    input  logic               clr_v_i
);

    localparam int unsigned IdxW = $clog2(els_p);
    localparam int unsigned PtrW = IdxW + 1;

    logic [width_p-1:0] mem_q [els_p];
    logic [PtrW-1:0]    wptr_q, wptr_d;
    logic [PtrW-1:0]    rptr_q, rptr_d;
    logic [PtrW-1:0]    cptr_q, cptr_d;
    logic [PtrW-1:0]    occ;
    logic               full;
    logic               unread;
    logic               bypass;
    logic               enq;

    // Status and read-side outputs; ready depends on registered pointers only
    always_comb begin
        occ    = wptr_q - cptr_q;
        full   = (occ == PtrW'(els_p));
        unread = (wptr_q != rptr_q);
        bypass = 1'b0;
`ifdef BP_BE_FE_QUEUE_BYPASS_EN
        bypass = ~unread & fe_queue_v_i & ~full & ~clr_v_i;
`endif
        enq              = fe_queue_v_i & ~full & ~clr_v_i;
        fe_queue_ready_o = ~full;
        fe_queue_v_o     = unread | bypass;
        fe_queue_o       = '0;
        if (unread) begin
            fe_queue_o = mem_q[rptr_q[IdxW-1:0]];
        end else if (bypass) begin
            fe_queue_o = fe_queue_i;
        end
    end

    // Pointer next-state: clear beats roll; roll rewinds to the post-commit pointer
    always_comb begin
        wptr_d = wptr_q + PtrW'(enq);
        cptr_d = cptr_q + PtrW'(deq_v_i);
        rptr_d = rptr_q + PtrW'(fe_queue_yumi_i);
        if (roll_v_i) begin
            rptr_d = cptr_d;
        end
        if (clr_v_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cptr_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    // Payload storage is not reset; pointers alone define which entries are live
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q[IdxW-1:0]] <= fe_queue_i;
        end
    end

`ifndef SYNTHESIS
    a_enq_full : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(fe_queue_v_i && !fe_queue_ready_o))
        else $error("enqueue while full");
    a_yumi_no_v : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(fe_queue_yumi_i && !fe_queue_v_o))
        else $error("yumi without valid");
    a_deq_unread : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(deq_v_i && (cptr_q == rptr_q)))
        else $error("commit with nothing read");
    a_deq_clr : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(deq_v_i && clr_v_i))
        else $error("commit together with clear");
`endif

endmodule
